// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: NUM_IN-operand bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR/
// PASS/ZERO) with per-operand mask, two registered stages with valid/ready flow
// control, and a wrapping count of results accepted at the output.
// Optional feature: define LOGIC_UNIT_PARITY_EN to register even parity of the
// result alongside out_data; otherwise out_par is tied low.
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_mask,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_par,
    output logic [CNT_W-1:0]        out_cnt
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_ZERO = 3'd7
    } op_e;

    // Stage 1: captured operand set
    logic                    s1_valid_q;
    logic [NUM_IN*WIDTH-1:0] s1_data_q;
    logic [NUM_IN-1:0]       s1_mask_q;
    logic [2:0]              s1_op_q;

    // Stage 2: computed result
    logic                    s2_valid_q;
    logic [WIDTH-1:0]        s2_data_q;

    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    logic [WIDTH-1:0]        red_and;
    logic [WIDTH-1:0]        red_or;
    logic [WIDTH-1:0]        red_xor;
    logic [WIDTH-1:0]        result_d;

    logic                    s1_ready;
    logic                    s2_ready;
    logic                    out_fire;

    // Each stage may load when it is empty or its contents move on this edge
    assign s2_ready  = !s2_valid_q || out_ready;
    assign s1_ready  = !s1_valid_q || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_cnt   = cnt_q;
    assign out_fire  = s2_valid_q && out_ready;

    // Masked reductions: skipped operands act as the identity of each reduction
    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (s1_mask_q[k]) begin
                red_and = red_and & s1_data_q[k*WIDTH +: WIDTH];
                red_or  = red_or  | s1_data_q[k*WIDTH +: WIDTH];
                red_xor = red_xor ^ s1_data_q[k*WIDTH +: WIDTH];
            end
        end
    end

    // Op select on the stage-1 operand set
    always_comb begin
        result_d = '0;
        case (op_e'(s1_op_q))
            OP_AND:  result_d = red_and;
            OP_OR:   result_d = red_or;
            OP_XOR:  result_d = red_xor;
            OP_NAND: result_d = ~red_and;
            OP_NOR:  result_d = ~red_or;
            OP_XNOR: result_d = ~red_xor;
            OP_PASS: result_d = s1_mask_q[0] ? s1_data_q[WIDTH-1:0] : '0;
            OP_ZERO: result_d = '0;
            default: result_d = '0;
        endcase
    end

    // Output transfer counter, wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stage 1 register: hold while stalled, load on input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_mask_q  <= '0;
            s1_op_q    <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_mask_q <= in_mask;
                s1_op_q   <= in_op;
            end
        end
    end

    // Stage 2 register: data only updates when a new result arrives, so
    // out_data keeps its last value while out_valid is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= result_d;
            end
        end
    end

    // Result counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic s2_par_q;

    // Parity register shares stage-2 load enable so it tracks out_data exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_par_q <= 1'b0;
        end else if (s2_ready && s1_valid_q) begin
            s2_par_q <= ^result_d;
        end
    end

    assign out_par = s2_par_q;
`else
    assign out_par = 1'b0;
`endif

endmodule
